// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one request outstanding to instruction memory,
// and hands words to decode through a one-entry output slot backed by a one-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_TakeBranch_M,
  input  logic [31:0] i_BranchTarget_M,
  input  logic        i_Stall_D,
  output logic        o_IMemReq,
  output logic [31:0] o_IMemAddr,
  input  logic        i_IMemAck,
  input  logic [31:0] i_IMemData,
  output logic        o_InstValid_D,
  output logic [31:0] o_Inst_D,
  output logic [31:0] o_Pc_D,
  output logic [31:0] o_PcPlus4_D,
  output logic        o_Flush
);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        slot_vld_q, slot_vld_d;
  logic [31:0] slot_inst_q, slot_inst_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        redirect, ack, accept, slot_free;
  logic [31:0] tgt;

  assign redirect  = i_TakeBranch_M;
  assign tgt       = i_BranchTarget_M & ~32'h3;
  // An ack with no request out is ignored rather than trusted.
  assign ack       = i_IMemAck & (state_q != IDLE);
  assign accept    = (state_q == REQ) & ack & ~redirect;
  assign slot_free = ~slot_vld_q | ~i_Stall_D;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_pc_d   = pend_pc_q;
    slot_vld_d  = slot_vld_q;
    slot_inst_d = slot_inst_q;
    slot_pc_d   = slot_pc_q;
    skid_vld_d  = skid_vld_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (redirect) begin
      slot_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (slot_free) begin
      if (skid_vld_q) begin
        slot_vld_d  = 1'b1;
        slot_inst_d = skid_inst_q;
        slot_pc_d   = skid_pc_q;
        skid_vld_d  = accept;
        if (accept) begin
          skid_inst_d = i_IMemData;
          skid_pc_d   = fetch_pc_q;
        end
      end else begin
        slot_vld_d = accept;
        if (accept) begin
          slot_inst_d = i_IMemData;
          slot_pc_d   = fetch_pc_q;
        end
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_inst_d = i_IMemData;
      skid_pc_d   = fetch_pc_q;
    end

    case (state_q)
      IDLE: begin
        if (redirect) fetch_pc_d = tgt;
        if (redirect || !skid_vld_q) state_d = REQ;
      end
      REQ: begin
        if (ack) begin
          fetch_pc_d = redirect ? tgt : fetch_pc_q + 32'd4;
          if (!redirect && skid_vld_d) state_d = IDLE;
        end else if (redirect) begin
          // Address must stay put until the in-flight access completes.
          pend_pc_d = tgt;
          state_d   = DISCARD;
        end
      end
      DISCARD: begin
        if (ack) begin
          fetch_pc_d = redirect ? tgt : pend_pc_q;
          state_d    = REQ;
        end else if (redirect) begin
          pend_pc_d = tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= RESET_PC;
      slot_vld_q  <= 1'b0;
      slot_inst_q <= NOP_INST;
      slot_pc_q   <= 32'd0;
      skid_vld_q  <= 1'b0;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      slot_vld_q  <= slot_vld_d;
      slot_inst_q <= slot_inst_d;
      slot_pc_q   <= slot_pc_d;
      skid_vld_q  <= skid_vld_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign o_IMemReq     = (state_q != IDLE);
  assign o_IMemAddr    = fetch_pc_q;
  assign o_InstValid_D = slot_vld_q;
  assign o_Inst_D      = slot_vld_q ? slot_inst_q : NOP_INST;
  assign o_Pc_D        = slot_pc_q;
  assign o_PcPlus4_D   = slot_pc_q + 32'd4;
  assign o_Flush       = i_TakeBranch_M & i_Rst_n;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, decode stall with skid, redirects, PC wrap, reset.
// Memory model acks whenever enabled and returns the inverted address as the instruction word.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, br, stall;
  logic [31:0] tgt;
  logic        ack_en;
  logic        req, vld, flush;
  logic [31:0] addr, inst, pc, pc4;
  logic        ack;
  logic [31:0] rdata;

  logic        rst2_n, ack_en2;
  logic        br2 = 1'b0, stall2 = 1'b0;
  logic [31:0] tgt2 = 32'd0;
  logic        req2, vld2, flush2;
  logic [31:0] addr2, inst2, pc2, pc42;
  logic        ack2;
  logic [31:0] rdata2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ack    = ack_en & req;
  assign rdata  = ~addr;
  assign ack2   = ack_en2 & req2;
  assign rdata2 = ~addr2;

  fetch_unit dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_TakeBranch_M(br), .i_BranchTarget_M(tgt),
    .i_Stall_D(stall), .o_IMemReq(req), .o_IMemAddr(addr), .i_IMemAck(ack),
    .i_IMemData(rdata), .o_InstValid_D(vld), .o_Inst_D(inst), .o_Pc_D(pc),
    .o_PcPlus4_D(pc4), .o_Flush(flush)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .i_Clk(clk), .i_Rst_n(rst2_n), .i_TakeBranch_M(br2), .i_BranchTarget_M(tgt2),
    .i_Stall_D(stall2), .o_IMemReq(req2), .o_IMemAddr(addr2), .i_IMemAck(ack2),
    .i_IMemData(rdata2), .o_InstValid_D(vld2), .o_Inst_D(inst2), .o_Pc_D(pc2),
    .o_PcPlus4_D(pc42), .o_Flush(flush2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; br = 1'b0; stall = 1'b0; tgt = 32'd0; ack_en = 1'b0;
    rst2_n = 1'b0; ack_en2 = 1'b0;
    tick();
    // Reset state; flush is masked while reset is asserted
    br = 1'b1; #1;
    chk("rst_flush", flush, 0);
    br = 1'b0; #1;
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_vld", vld, 0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'h0);

    // Streaming
    rst_n = 1'b1; ack_en = 1'b1;
    tick();
    chk("s1_req", req, 1);
    chk("s1_addr", addr, 32'h0);
    chk("s1_vld", vld, 0);
    tick();
    chk("s2_vld", vld, 1);
    chk("s2_pc", pc, 32'h0);
    chk("s2_inst", inst, 32'hFFFF_FFFF);
    chk("s2_pc4", pc4, 32'h4);
    chk("s2_addr", addr, 32'h4);
    tick();
    chk("s3_pc", pc, 32'h4);
    chk("s3_inst", inst, ~32'h4);
    chk("s3_addr", addr, 32'h8);
    tick();
    chk("s4_pc", pc, 32'h8);
    chk("s4_vld", vld, 1);
    chk("s4_addr", addr, 32'hC);

    // Decode stall: slot holds 0x8, skid takes 0xC, fetch goes idle
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_req", req, 0);
      chk("stall_pc", pc, 32'h8);
      chk("stall_vld", vld, 1);
      chk("stall_addr", addr, 32'h10);
    end
    stall = 1'b0;
    tick();
    chk("drain_pc", pc, 32'hC);
    chk("drain_inst", inst, ~32'hC);
    chk("drain_vld", vld, 1);
    chk("drain_req", req, 0);
    tick();
    chk("rereq_req", req, 1);
    chk("rereq_addr", addr, 32'h10);
    chk("rereq_vld", vld, 0);
    tick();
    chk("resume_pc", pc, 32'h10);
    chk("resume_vld", vld, 1);
    tick(); tick(); tick();
    chk("pre_br_addr", addr, 32'h20);
    chk("pre_br_pc", pc, 32'h1C);

    // Redirect to 0x100 while 0x20 is outstanding
    ack_en = 1'b0; br = 1'b1; tgt = 32'h100; #1;
    chk("br1_flush", flush, 1);
    tick();
    br = 1'b0; #1;
    chk("br1_flush_off", flush, 0);
    chk("disc_vld", vld, 0);
    chk("disc_inst", inst, NOP);
    chk("disc_addr", addr, 32'h20);
    chk("disc_req", req, 1);
    tick();
    chk("disc_hold", addr, 32'h20);
    ack_en = 1'b1;
    tick();
    chk("tgt1_addr", addr, 32'h100);
    chk("tgt1_vld", vld, 0);
    tick();
    chk("tgt1_pc", pc, 32'h100);
    chk("tgt1_inst", inst, ~32'h100);
    chk("tgt1_valid", vld, 1);

    // Redirect to unaligned 0x203 coincident with the ack of 0x104
    br = 1'b1; tgt = 32'h203;
    tick();
    br = 1'b0;
    chk("br2_addr", addr, 32'h200);
    chk("br2_vld", vld, 0);
    chk("br2_inst", inst, NOP);
    tick();
    chk("br2_pc", pc, 32'h200);
    chk("br2_data", inst, ~32'h200);

    // Two redirects during DISCARD, newest wins
    ack_en = 1'b0; br = 1'b1; tgt = 32'h40;
    tick();
    chk("dd1_addr", addr, 32'h204);
    tgt = 32'h80;
    tick();
    chk("dd2_addr", addr, 32'h204);
    br = 1'b0; ack_en = 1'b1;
    tick();
    chk("dd_addr", addr, 32'h80);
    tick();
    chk("dd_pc", pc, 32'h80);
    chk("dd_vld", vld, 1);

    // PC wrap on the second instance
    rst2_n = 1'b1; ack_en2 = 1'b1;
    tick();
    chk("w_addr0", addr2, 32'hFFFF_FFF8);
    tick();
    chk("w_pc0", pc2, 32'hFFFF_FFF8);
    chk("w_addr1", addr2, 32'hFFFF_FFFC);
    tick();
    chk("w_pc1", pc2, 32'hFFFF_FFFC);
    chk("w_pc4_1", pc42, 32'h0);
    chk("w_addr2", addr2, 32'h0);
    tick();
    chk("w_pc2", pc2, 32'h0);
    chk("w_addr3", addr2, 32'h4);

    // Reset mid-request: everything returns to reset values at once
    ack_en2 = 1'b0;
    #3;
    rst2_n = 1'b0;
    #1;
    chk("mr_req", req2, 0);
    chk("mr_vld", vld2, 0);
    chk("mr_inst", inst2, NOP);
    chk("mr_pc", pc2, 32'h0);
    chk("mr_addr", addr2, 32'hFFFF_FFF8);
    chk("mr_flush", flush2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter, issues single-outstanding requests to instruction memory and presents fetched instructions to decode.
- Consumes the memory-stage redirect (take-branch flag plus target) produced by the branch unit; on redirect it flushes the front end and resumes fetching at the target.
- Sits between the M-stage branch resolution and the F/D pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset
NOP_INST, 32'h0000_0013, instruction word driven on o_Inst_D when no instruction is held

Ports:
i_Clk  in  1  clock; all state updates on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_TakeBranch_M  in  1  redirect request from branch unit (branch taken or jump)
i_BranchTarget_M  in  32  redirect target address
i_Stall_D  in  1  decode cannot accept an instruction this cycle
o_IMemReq  out  1  instruction memory request
o_IMemAddr  out  32  request address; bits [1:0] always 0
i_IMemAck  in  1  memory completes request this cycle
i_IMemData  in  32  instruction word, valid when i_IMemAck=1
o_InstValid_D  out  1  o_Inst_D/o_Pc_D hold a valid instruction
o_Inst_D  out  32  instruction to decode
o_Pc_D  out  32  address of o_Inst_D
o_PcPlus4_D  out  32  o_Pc_D + 4, mod 2^32
o_Flush  out  1  squash younger F/D/E stages

Behaviour:
- Reset (async, while i_Rst_n=0): state IDLE, o_IMemReq=0, FetchPc=RESET_PC, o_IMemAddr=RESET_PC, o_InstValid_D=0, o_Inst_D=NOP_INST, o_Pc_D=0, skid buffer empty.
- o_Flush = i_TakeBranch_M & i_Rst_n, combinational, same cycle as the redirect.
- Mid-request reset: request is abandoned immediately; instruction memory must tolerate a dropped request.
- Memory handshake:
  - o_IMemReq=1 in states REQ and DISCARD.
  - o_IMemAddr stays stable until a cycle with i_IMemAck=1.
  - Ack is sampled at the rising edge; at most one request is outstanding.
  - Back-to-back requests are allowed: after an ack the next address appears in the following cycle.
- Output slot (1 entry) plus skid buffer (1 entry):
  - Slot is consumed when o_InstValid_D=1 and i_Stall_D=0.
  - An accepted ack goes to the slot if the slot is empty or being consumed; otherwise it goes to the skid buffer.
  - When the slot frees, the skid contents move into it.
  - Data reaches o_Inst_D the cycle after the ack (registered).
- Redirect priority: i_TakeBranch_M overrides i_Stall_D. On redirect, slot and skid are cleared (o_InstValid_D=0, o_Inst_D=NOP_INST next cycle) and FetchPc or PendingPc = {target[31:2],2'b00}.
- FSM:
  - IDLE: no request. If skid empty (or redirect this cycle) → REQ next cycle at FetchPc.
  - REQ:
    - ack and no redirect: accept data; FetchPc+=4 (wraps 0xFFFFFFFC→0). Go IDLE if skid becomes full, else stay REQ.
    - ack and redirect: drop data; FetchPc=target; stay REQ.
    - no ack and redirect: PendingPc=target; → DISCARD, holding the old address.
    - no ack, no redirect: stay.
  - DISCARD:
    - Further redirects overwrite PendingPc (newest wins).
    - On ack: drop data; FetchPc=PendingPc (or the same-cycle redirect target); → REQ.
- Redirect latency:
  - Redirect in cycle N with no outstanding request, or with an ack in N: target address appears on o_IMemAddr in N+1.
  - Otherwise the target is issued the cycle after the discarded ack.
- o_PcPlus4_D = o_Pc_D+4, modulo 2^32.

Test Plan:
- Reset release, memory acks every cycle, no stalls → o_IMemAddr 0x0,0x4,0x8…; o_Inst_D follows one cycle after each ack with matching o_Pc_D; o_InstValid_D continuous.
- Hold i_Stall_D=1 for 4 cycles during streaming → slot holds its instruction, skid captures one more, o_IMemReq drops (IDLE). On release, both instructions reach decode in order with none lost or duplicated.
- i_TakeBranch_M=1, target 0x100, while a request to 0x20 is un-acked → o_Flush=1 that cycle, o_InstValid_D=0 next cycle, address held at 0x20 until ack, that data dropped, then o_IMemAddr=0x100 and the first delivered o_Pc_D=0x100.
- Redirect to 0x203 in the same cycle as an ack → ack data never appears; next o_IMemAddr=0x200.
- Two redirects (0x40, then 0x80) during DISCARD → only 0x80 is fetched; 0x40 is never requested.
- RESET_PC=32'hFFFF_FFF8 with streaming → addresses FFFFFFF8, FFFFFFFC, 00000000; o_PcPlus4_D for FFFFFFFC is 0. Assert i_Rst_n=0 mid-request → o_IMemReq=0 immediately and all outputs return to reset values.
